// File: rtl/axi4_slave_pkg.sv
// Shared types for the AXI4 slave read path: burst encodings, response
// codes and the R-channel controller state encoding.
package axi4_slave_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    LOAD  = 2'b10,
    SEND  = 2'b11
  } rd_state_e;

  // True when len+1 is a legal wrapping burst length (2, 4, 8 or 16 beats).
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
// The caller passes the already-sanitised burst type; RSVD is treated
// as FIXED here as well so the block is safe on its own.
module axi4_burst_addr_gen
  import axi4_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] cur,
  input  logic [ADDR_WIDTH-1:0] start,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  burst_e                burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_len;
  logic [ADDR_WIDTH-1:0] wrap_lower;

  assign bytes      = ADDR_WIDTH'(1) << size;
  assign incr_addr  = cur + bytes;
  assign wrap_len   = bytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
  assign wrap_lower = start & ~(wrap_len - ADDR_WIDTH'(1));

  // Select the next address by burst type; wrap back to the aligned base at the window edge.
  always_comb begin
    // NOTE: a default assignment first guarantees every path drives next_addr, so no latch is inferred.
    next_addr = cur;
    case (burst)
      INCR:    next_addr = incr_addr;
      WRAP:    next_addr = (incr_addr == wrap_lower + wrap_len) ? wrap_lower : incr_addr;
      default: next_addr = cur;
    endcase
  end

endmodule

// File: rtl/axi4_slave_read_burst_ctrl.sv
// AXI4 slave R-channel sequencer: accepts a latched AR request, fetches one
// beat at a time from a synchronous memory and presents it on R under
// rready backpressure. Each beat takes FETCH -> LOAD -> SEND (>= 3 cycles).
module axi4_slave_read_burst_ctrl
  import axi4_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ar_transfer_occurred,
  input  logic [ADDR_WIDTH-1:0] latched_araddr,
  input  logic [ID_WIDTH-1:0]   latched_arid,
  input  logic [7:0]            latched_arlen,
  input  logic [2:0]            latched_arsize,
  input  logic [1:0]            latched_arburst,
  output logic                  rd_busy,
  output logic                  ar_overrun,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_err,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [1:0]            rresp,
  output logic                  rlast
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

  rd_state_e             state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic [2:0]            size_q;
  burst_e                burst_q;
  logic                  err_q;

  burst_e                cap_burst;
  logic                  cap_err;
  logic                  last_hs;
  logic                  accept;

  // The memory address is the current-address register itself.
  assign mem_rd_addr = cur_addr;

  // A new request is taken when idle, or on the handshake of the final beat.
  assign last_hs = (state == SEND) && rvalid && rready && rlast;
  assign accept  = ar_transfer_occurred && ((state == IDLE) || last_hs);

  // Sanitise the incoming burst: flag illegal requests and pick a safe address mode.
  always_comb begin
    cap_burst = burst_e'(latched_arburst);
    cap_err   = 1'b0;
    if (latched_arburst == RSVD) begin
      cap_err   = 1'b1;
      cap_burst = FIXED;
    end else if ((latched_arburst == WRAP) && !wrap_len_ok(latched_arlen)) begin
      cap_err   = 1'b1;
      cap_burst = INCR;
    end
    if (latched_arsize > 3'(MAX_SIZE)) begin
      cap_err = 1'b1;
    end
  end

  axi4_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .cur       (cur_addr),
    .start     (start_addr),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Burst sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= IDLE;
      cur_addr   <= '0;
      start_addr <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      size_q     <= '0;
      burst_q    <= FIXED;
      err_q      <= 1'b0;
      rd_busy    <= 1'b0;
      ar_overrun <= 1'b0;
      mem_rd_en  <= 1'b0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      rid        <= '0;
      rresp      <= RESP_OKAY;
      rlast      <= 1'b0;
    end else begin
      mem_rd_en  <= 1'b0;
      ar_overrun <= ar_transfer_occurred && !accept;

      case (state)
        IDLE: begin
          rd_busy <= 1'b0;
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          rdata  <= mem_rd_data;
          rresp  <= (err_q || mem_rd_err) ? RESP_SLVERR : RESP_OKAY;
          rlast  <= (beat_cnt == len_q);
          rvalid <= 1'b1;
          state  <= SEND;
        end
        SEND: begin
          if (rready) begin
            rvalid <= 1'b0;
            if (rlast) begin
              state   <= IDLE;
              rd_busy <= 1'b0;
            end else begin
              cur_addr  <= next_addr;
              beat_cnt  <= beat_cnt + 8'd1;
              mem_rd_en <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // NOTE: placed after the case so these later non-blocking writes win over the IDLE/SEND defaults.
      if (accept) begin
        cur_addr   <= latched_araddr;
        start_addr <= latched_araddr;
        rid        <= latched_arid;
        len_q      <= latched_arlen;
        size_q     <= latched_arsize;
        burst_q    <= cap_burst;
        err_q      <= cap_err;
        beat_cnt   <= '0;
        mem_rd_en  <= 1'b1;
        rd_busy    <= 1'b1;
        state      <= FETCH;
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_read_burst_ctrl.sv
// Directed bench for axi4_slave_read_burst_ctrl. Expected beats are computed
// from the burst rules when a request is issued, queued, and popped as the
// DUT completes R handshakes. Memory contents are a fixed function of address.
module tb_axi4_slave_read_burst_ctrl;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_transfer_occurred;
  logic [31:0] latched_araddr;
  logic [3:0]  latched_arid;
  logic [7:0]  latched_arlen;
  logic [2:0]  latched_arsize;
  logic [1:0]  latched_arburst;
  logic        rd_busy;
  logic        ar_overrun;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        mem_rd_err;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;

  int    checks   = 0;
  int    failures = 0;
  int    fetch_cnt;
  int    err_fetch_idx = -1;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  axi4_slave_read_burst_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ID_WIDTH   (4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ar_transfer_occurred (ar_transfer_occurred),
    .latched_araddr       (latched_araddr),
    .latched_arid         (latched_arid),
    .latched_arlen        (latched_arlen),
    .latched_arsize       (latched_arsize),
    .latched_arburst      (latched_arburst),
    .rd_busy              (rd_busy),
    .ar_overrun           (ar_overrun),
    .mem_rd_en            (mem_rd_en),
    .mem_rd_addr          (mem_rd_addr),
    .mem_rd_data          (mem_rd_data),
    .mem_rd_err           (mem_rd_err),
    .rvalid               (rvalid),
    .rready               (rready),
    .rdata                (rdata),
    .rid                  (rid),
    .rresp                (rresp),
    .rlast                (rlast)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Synchronous memory: data one cycle after the strobe, optional error on a chosen fetch.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt   <= 0;
      mem_rd_data <= '0;
      mem_rd_err  <= 1'b0;
    end else begin
      mem_rd_err <= 1'b0;
      if (mem_rd_en) begin
        mem_rd_data <= mem_f(mem_rd_addr);
        mem_rd_err  <= (fetch_cnt == err_fetch_idx);
        fetch_cnt   <= fetch_cnt + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expected beats derived from the burst rules (address sequence, error flag, last).
  task automatic push_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int err_beat);
    logic [31:0] a, bytes, wlen, lower;
    logic        err;
    logic [1:0]  mode;
    beat_t       b;
    a     = addr;
    bytes = 32'd1 << size;
    err   = (size > 3'd2);
    mode  = burst;
    if (burst == 2'b11) begin
      err  = 1'b1;
      mode = 2'b00;
    end else if (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
      err  = 1'b1;
      mode = 2'b01;
    end
    wlen  = bytes * ({24'd0, len} + 32'd1);
    lower = addr & ~(wlen - 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      b.data = mem_f(a);
      b.resp = (err || i == err_beat) ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      b.id   = id;
      exp_q.push_back(b);
      if (mode == 2'b01) a = a + bytes;
      else if (mode == 2'b10) begin
        a = a + bytes;
        if (a == lower + wlen) a = lower;
      end
    end
  endtask

  // Drive a one-cycle AR pulse starting now; returns at the following negedge.
  task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int err_beat,
                         input bit expect_beats);
    ar_transfer_occurred = 1'b1;
    latched_araddr       = addr;
    latched_arid         = id;
    latched_arlen        = len;
    latched_arsize       = size;
    latched_arburst      = burst;
    if (expect_beats) push_burst(addr, id, len, size, burst, err_beat);
    step();
    ar_transfer_occurred = 1'b0;
  endtask

  // Wait (bounded) for an R handshake at a negedge sample and score it; stays on that negedge.
  task automatic beat(input string tag);
    int    n = 0;
    beat_t e;
    while (!(rvalid && rready) && n < 40) begin
      step();
      n++;
    end
    if (!(rvalid && rready)) begin
      check({tag, "_timeout"}, {63'd0, rvalid}, 64'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_rdata"}, {32'd0, rdata}, {32'd0, e.data});
    check({tag, "_rresp"}, {62'd0, rresp}, {62'd0, e.resp});
    check({tag, "_rlast"}, {63'd0, rlast}, {63'd0, e.last});
    check({tag, "_rid"},   {60'd0, rid},   {60'd0, e.id});
  endtask

  task automatic run_beats(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      beat($sformatf("%s_b%0d", tag, i));
      step();
    end
  endtask

  initial begin
    rst                  = 1'b0;
    rready               = 1'b1;
    ar_transfer_occurred = 1'b0;
    latched_araddr       = '0;
    latched_arid         = '0;
    latched_arlen        = '0;
    latched_arsize       = '0;
    latched_arburst      = '0;
    repeat (3) step();

    // Reset state
    check("rst_rvalid",   {63'd0, rvalid},    64'd0);
    check("rst_rd_busy",  {63'd0, rd_busy},   64'd0);
    check("rst_mem_en",   {63'd0, mem_rd_en}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_rd_addr}, 64'd0);
    check("rst_rdata",    {32'd0, rdata},     64'd0);
    rst = 1'b1;
    repeat (2) step();

    // INCR, 4 beats, with first-beat latency
    send_ar(32'h100, 4'h5, 8'd3, 3'd2, 2'b01, -1, 1'b1);
    check("t1_fetch_en",   {63'd0, mem_rd_en},   64'd1);
    check("t1_fetch_addr", {32'd0, mem_rd_addr}, 64'h100);
    check("t1_busy",       {63'd0, rd_busy},     64'd1);
    check("t1_rvalid_t1",  {63'd0, rvalid},      64'd0);
    step();
    check("t1_rvalid_t2",  {63'd0, rvalid},      64'd0);
    check("t1_load_en",    {63'd0, mem_rd_en},   64'd0);
    step();
    check("t1_rvalid_t3",  {63'd0, rvalid},      64'd1);
    run_beats(4, "t1");
    check("t1_idle_busy",  {63'd0, rd_busy},     64'd0);

    // WRAP legal and illegal length
    send_ar(32'h108, 4'h1, 8'd3, 3'd2, 2'b10, -1, 1'b1);
    run_beats(4, "t2_wrap");
    send_ar(32'h108, 4'h2, 8'd2, 3'd2, 2'b10, -1, 1'b1);
    run_beats(3, "t2_badwrap");

    // FIXED, reserved burst, oversized beat
    send_ar(32'h40, 4'h3, 8'd2, 3'd2, 2'b00, -1, 1'b1);
    run_beats(3, "t3_fixed");
    send_ar(32'h80, 4'h4, 8'd1, 3'd2, 2'b11, -1, 1'b1);
    run_beats(2, "t3_rsvd");
    send_ar(32'h300, 4'h7, 8'd1, 3'd3, 2'b01, -1, 1'b1);
    run_beats(2, "t3_size");

    // Backpressure on first beat
    rready = 1'b0;
    begin
      int f0;
      int n;
      f0 = fetch_cnt;
      send_ar(32'h500, 4'h3, 8'd1, 3'd2, 2'b01, -1, 1'b1);
      n = 0;
      while (!rvalid && n < 20) begin
        step();
        n++;
      end
      check("t4_rvalid_up", {63'd0, rvalid}, 64'd1);
      for (int i = 0; i < 5; i++) begin
        step();
        check($sformatf("t4_hold_rvalid_%0d", i), {63'd0, rvalid}, 64'd1);
        check($sformatf("t4_hold_rdata_%0d", i),  {32'd0, rdata},  {32'd0, exp_q[0].data});
        check($sformatf("t4_hold_rlast_%0d", i),  {63'd0, rlast},  {63'd0, exp_q[0].last});
      end
      check("t4_no_refetch", 64'(fetch_cnt), 64'(f0 + 1));
    end
    rready = 1'b1;
    run_beats(2, "t4");

    // Memory error on beat 2 of 4
    err_fetch_idx = fetch_cnt + 1;
    send_ar(32'h900, 4'h8, 8'd3, 3'd2, 2'b01, 1, 1'b1);
    run_beats(4, "t5_err");
    err_fetch_idx = -1;

    // Overrun mid-burst, then a pulse on the final handshake
    send_ar(32'h700, 4'h6, 8'd2, 3'd2, 2'b01, -1, 1'b1);
    beat("t5_ovr_b0");
    step();
    send_ar(32'hDEAD_0000, 4'hF, 8'd5, 3'd2, 2'b01, -1, 1'b0);
    check("t5_overrun_hi", {63'd0, ar_overrun}, 64'd1);
    step();
    check("t5_overrun_lo", {63'd0, ar_overrun}, 64'd0);
    beat("t5_ovr_b1");
    step();
    beat("t5_ovr_b2");
    send_ar(32'h800, 4'hA, 8'd0, 3'd2, 2'b01, -1, 1'b1);
    check("t5_b2b_fetch",   {63'd0, mem_rd_en},   64'd1);
    check("t5_b2b_addr",    {32'd0, mem_rd_addr}, 64'h800);
    check("t5_b2b_overrun", {63'd0, ar_overrun},  64'd0);
    run_beats(1, "t5_b2b");
    check("t5_idle_busy",   {63'd0, rd_busy},     64'd0);

    // Reset during beat 2 SEND
    send_ar(32'h200, 4'hB, 8'd3, 3'd2, 2'b01, -1, 1'b1);
    beat("t6_b0");
    step();
    begin
      int n = 0;
      while (!rvalid && n < 20) begin
        step();
        n++;
      end
      check("t6_beat2_valid", {63'd0, rvalid}, 64'd1);
    end
    rst = 1'b0;
    #1;
    check("t6_rst_rvalid", {63'd0, rvalid},      64'd0);
    check("t6_rst_busy",   {63'd0, rd_busy},     64'd0);
    check("t6_rst_rlast",  {63'd0, rlast},       64'd0);
    check("t6_rst_rdata",  {32'd0, rdata},       64'd0);
    check("t6_rst_rid",    {60'd0, rid},         64'd0);
    check("t6_rst_addr",   {32'd0, mem_rd_addr}, 64'd0);
    exp_q.delete();
    step();
    rst = 1'b1;
    step();
    send_ar(32'h600, 4'h9, 8'd0, 3'd2, 2'b01, -1, 1'b1);
    run_beats(1, "t6_post");
    repeat (3) step();
    check("t6_final_busy",  {63'd0, rd_busy},  64'd0);
    check("t6_final_valid", {63'd0, rvalid},   64'd0);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_slave_read_burst_ctrl.md
Name: axi4_slave_read_burst_ctrl

Overview:
Sequences the AXI4 slave read data (R) channel. It takes the AR-channel handshake pulse and the latched AR fields, then generates per-beat memory read addresses for FIXED, INCR and WRAP bursts. It drives rvalid/rdata/rid/rresp/rlast under rready backpressure. It sits between the read-address block and the slave memory, and exports rd_busy so the top level gates arvalid while a burst is in flight.

Parameters:
ADDR_WIDTH, 32, address width in bits.
DATA_WIDTH, 32, R data width in bits (power of 2, at least 8).
ID_WIDTH, 4, transaction ID width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ar_transfer_occurred  in  1  one-cycle pulse; latched_* fields valid in the same cycle
latched_araddr  in  ADDR_WIDTH  burst start address
latched_arid  in  ID_WIDTH  burst ID
latched_arlen  in  8  beats minus 1
latched_arsize  in  3  log2(bytes per beat)
latched_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
rd_busy  out  1  high while a burst is in flight
ar_overrun  out  1  one-cycle pulse; AR pulse dropped because the controller was busy
mem_rd_en  out  1  synchronous memory read strobe
mem_rd_addr  out  ADDR_WIDTH  memory read address
mem_rd_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en
mem_rd_err  in  1  decode error, same timing as mem_rd_data
rvalid  out  1  AXI R valid
rready  in  1  AXI R ready
rdata  out  DATA_WIDTH  AXI R data
rid  out  ID_WIDTH  AXI R ID
rresp  out  2  AXI R response: 00 OKAY, 10 SLVERR
rlast  out  1  AXI R last beat

Behaviour:
- Reset (async, rst=0): state IDLE. All outputs 0. Internal address, beat counter and error flag cleared. Reset mid-burst abandons the burst with no further beats.
- All outputs are registered except mem_rd_addr, which is driven from the current-address register.
- State machine:
  - IDLE: on an accepted pulse, capture the AR fields into cur_addr, id, len, size, burst; beat_cnt=0; go to FETCH.
  - FETCH: mem_rd_en=1 for exactly one cycle; go to LOAD.
  - LOAD: at the clock edge, register rdata=mem_rd_data, rresp and rlast; rvalid<=1; go to SEND.
  - SEND: hold rvalid, rdata, rresp, rlast and rid stable until rready=1.
    - On handshake with rlast=1: rvalid<=0; go to IDLE, or go to FETCH if a new pulse arrives in that same cycle.
    - On handshake otherwise: cur_addr<=next_addr; beat_cnt++; go to FETCH.
- Timing: a pulse in cycle T gives FETCH in T+1, LOAD in T+2, and rvalid high in T+3. Minimum 3 cycles per beat.
- rd_busy = (state != IDLE), registered.
- Pulse acceptance: a pulse is accepted when state is IDLE, or on the final-beat handshake cycle. Any other pulse is dropped and ar_overrun=1 next cycle; the current burst is unaffected.
- rlast = (beat_cnt == len). len=0 gives a single beat with rlast=1.
- Address arithmetic:
  - bytes = 1 << size.
  - FIXED: next = cur.
  - INCR: next = cur + bytes, modulo 2^ADDR_WIDTH. No 4KB check.
  - WRAP: wlen = bytes*(len+1); lower = start & ~(wlen-1); next = cur + bytes, and if next == lower + wlen then next = lower.
- Burst errors: the error flag is set at capture if any of these hold:
  - burst == 11; the address is then held as FIXED.
  - burst == WRAP and len is not 1, 3, 7 or 15; the address then advances as INCR.
  - size > log2(DATA_WIDTH/8).
- rresp: SLVERR when the error flag or mem_rd_err is set for that beat, else OKAY. mem_rd_err affects only its own beat.
- rid equals the captured arid for every beat of the burst.

Decomposition:
- Package axi4_slave_pkg holds:
  - burst enum: FIXED/INCR/WRAP/RSVD;
  - response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - R-controller state enum: IDLE/FETCH/LOAD/SEND.
- One combinational sub-module, axi4_burst_addr_gen, takes cur, start, len, size, burst and produces next_addr.

Test Plan:
1. INCR, addr 0x100, len 3, size 2, id 0x5, rready=1 -> mem_rd_addr 0x100/0x104/0x108/0x10C; rvalid first at T+3; rlast only on beat 4; rid=5; rresp=00.
2. WRAP, addr 0x108, len 3, size 2 -> addresses 0x108/0x10C/0x100/0x104, all OKAY. WRAP with len 2 -> 3 beats, all rresp=10.
3. FIXED, addr 0x40, len 2 -> 0x40 three times. Burst 11 -> all beats SLVERR, address held.
4. rready low for 5 cycles on beat 1 of an INCR burst -> rvalid/rdata/rlast stable, no extra mem_rd_en, then completes normally.
5. mem_rd_err=1 on beat 2 of 4 -> rresp=10 on beat 2 only. A pulse mid-burst -> ar_overrun one cycle, burst unchanged. A pulse on the final handshake cycle -> FETCH next cycle, no overrun.
6. rst=0 during beat 2 SEND -> all outputs 0 immediately; after release, a new len-0 burst returns one beat with rlast=1.
